// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset control FSM: sequences fetch/decode/execute/memory/writeback
// and guards every memory handshake with a bounded wait counter.
module multicycle_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [6:0] opcode_i,
   input  logic       brflag_i,
   input  logic       mem_ready_i,
   output logic       pc_we_o,
   output logic       ir_we_o,
   output logic       iord_o,
   output logic       memread_o,
   output logic       memwrite_o,
   output logic       regwrite_o,
   output logic       memtoreg_o,
   output logic       alusrca_o,
   output logic [1:0] alusrcb_o,
   output logic [1:0] aluop_o,
   output logic       pcsrc_o,
   output logic [2:0] state_o,
   output logic       retire_o,
   output logic       err_o
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT - 1);

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEMACC = 3'd3,
      WBACK  = 3'd4,
      BRANCH = 3'd5,
      HALT   = 3'd6
   } state_e;

   state_e          state_q, state_d;
   logic [6:0]      opcode_q, opcode_d;
   logic [CW-1:0]   wait_q, wait_d;
   logic            err_q, err_d;
   logic            waiting;
   logic            timedOut;

   // A handshake cycle without ready; the last allowed one times out instead of waiting on
   assign waiting  = ((state_q == FETCH) || (state_q == MEMACC)) && !mem_ready_i;
   assign timedOut = waiting && (wait_q == WAIT_LIMIT);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= FETCH;
         opcode_q <= '0;
         wait_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         wait_q   <= wait_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      case (state_q)
         FETCH: begin
            if (mem_ready_i)   state_d = DECODE;
            else if (timedOut) state_d = HALT;
         end
         DECODE: begin
            opcode_d = opcode_i;
            case (opcode_i)
               OP_R, OP_I, OP_LD, OP_ST: state_d = EXEC;
               OP_BR:                    state_d = BRANCH;
               default:                  state_d = HALT;
            endcase
         end
         EXEC: begin
            if ((opcode_q == OP_LD) || (opcode_q == OP_ST)) state_d = MEMACC;
            else                                            state_d = WBACK;
         end
         MEMACC: begin
            if (mem_ready_i)   state_d = (opcode_q == OP_LD) ? WBACK : FETCH;
            else if (timedOut) state_d = HALT;
         end
         WBACK:   state_d = FETCH;
         BRANCH:  state_d = FETCH;
         HALT:    state_d = HALT;
         default: state_d = HALT;
      endcase
      err_d  = err_q || (state_d == HALT);
      wait_d = (waiting && (state_d == state_q)) ? wait_q + CW'(1) : '0;
   end

   // Outputs are forced low for the whole time reset is held, even though FETCH asserts memread
   always_comb begin
      pc_we_o    = 1'b0;
      ir_we_o    = 1'b0;
      iord_o     = 1'b0;
      memread_o  = 1'b0;
      memwrite_o = 1'b0;
      regwrite_o = 1'b0;
      memtoreg_o = 1'b0;
      alusrca_o  = 1'b0;
      alusrcb_o  = 2'b00;
      aluop_o    = 2'b00;
      pcsrc_o    = 1'b0;
      retire_o   = 1'b0;
      case (state_q)
         FETCH: begin
            memread_o = 1'b1;
            alusrcb_o = 2'b01;
            ir_we_o   = mem_ready_i;
            pc_we_o   = mem_ready_i;
         end
         DECODE: alusrcb_o = 2'b11;
         EXEC: begin
            alusrca_o = 1'b1;
            if ((opcode_q == OP_R)) begin
               alusrcb_o = 2'b00;
               aluop_o   = 2'b10;
            end else if (opcode_q == OP_I) begin
               alusrcb_o = 2'b10;
               aluop_o   = 2'b10;
            end else begin
               alusrcb_o = 2'b10;
               aluop_o   = 2'b00;
            end
         end
         MEMACC: begin
            iord_o     = 1'b1;
            memread_o  = (opcode_q == OP_LD);
            memwrite_o = (opcode_q == OP_ST);
            retire_o   = (opcode_q == OP_ST) && mem_ready_i;
         end
         WBACK: begin
            regwrite_o = 1'b1;
            retire_o   = 1'b1;
            memtoreg_o = (opcode_q == OP_LD);
         end
         BRANCH: begin
            alusrca_o = 1'b1;
            aluop_o   = 2'b01;
            pcsrc_o   = 1'b1;
            pc_we_o   = brflag_i;
            retire_o  = 1'b1;
         end
         default: ;
      endcase
      if (!rst_ni) begin
         {pc_we_o, ir_we_o, iord_o, memread_o, memwrite_o, regwrite_o, memtoreg_o,
          alusrca_o, alusrcb_o, aluop_o, pcsrc_o, retire_o} = '0;
      end
   end

   assign state_o = state_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected cycle-by-cycle
// trace from the control rules, then replayed against the DUT.
module tb_multicycle_ctrl;

   localparam int TO = 4;

   localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEMACC = 3'd3,
                          S_WBACK = 3'd4, S_BRANCH = 3'd5, S_HALT = 3'd6;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   typedef struct packed {
      logic       pcWe;
      logic       irWe;
      logic       iord;
      logic       memRead;
      logic       memWrite;
      logic       regWrite;
      logic       memToReg;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic       pcSrc;
      logic       retire;
      logic       err;
   } outs_t;

   typedef struct {
      logic [2:0] st;
      logic       rdy;
      logic       br;
      logic [6:0] op;
      outs_t      o;
   } cyc_t;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b1;
   logic [6:0] opcode_i = '0;
   logic       brflag_i = 1'b0;
   logic       mem_ready_i = 1'b0;
   logic       pc_we_o, ir_we_o, iord_o, memread_o, memwrite_o, regwrite_o, memtoreg_o;
   logic       alusrca_o, pcsrc_o, retire_o, err_o;
   logic [1:0] alusrcb_o, aluop_o;
   logic [2:0] state_o;

   int   compared = 0;
   int   mismatched = 0;
   int   cycleNo = 0;
   cyc_t plan[$];

   multicycle_ctrl #(.TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .brflag_i(brflag_i),
      .mem_ready_i(mem_ready_i), .pc_we_o(pc_we_o), .ir_we_o(ir_we_o), .iord_o(iord_o),
      .memread_o(memread_o), .memwrite_o(memwrite_o), .regwrite_o(regwrite_o),
      .memtoreg_o(memtoreg_o), .alusrca_o(alusrca_o), .alusrcb_o(alusrcb_o),
      .aluop_o(aluop_o), .pcsrc_o(pcsrc_o), .state_o(state_o), .retire_o(retire_o),
      .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic outs_t observed();
      outs_t o;
      o = {pc_we_o, ir_we_o, iord_o, memread_o, memwrite_o, regwrite_o, memtoreg_o,
           alusrca_o, alusrcb_o, aluop_o, pcsrc_o, retire_o, err_o};
      return o;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cycleNo, obs, exp);
      end
   endtask

   task automatic pushCyc(input logic [2:0] st, input logic rdy, input logic br,
                          input logic [6:0] op, input outs_t o);
      cyc_t c;
      c.st = st; c.rdy = rdy; c.br = br; c.op = op; c.o = o;
      plan.push_back(c);
   endtask

   task automatic planHalt();
      outs_t o;
      o = '0;
      o.err = 1'b1;
      for (int i = 0; i < 3; i++) pushCyc(S_HALT, 1'($urandom), 1'($urandom), 7'($urandom), o);
   endtask

   // Expected trace of one instruction: fw/mw are wait cycles before ready in fetch/memory
   task automatic planInstr(input logic [6:0] opc, input int fw, input int mw, input logic br,
                            output bit halted);
      outs_t o;
      bit    isLoad, isStore;
      halted  = 1'b0;
      isLoad  = (opc == OP_LD);
      isStore = (opc == OP_ST);
      o = '0;
      o.memRead = 1'b1;
      o.aluSrcB = 2'b01;
      for (int i = 0; i < ((fw >= TO) ? TO : fw); i++)
         pushCyc(S_FETCH, 1'b0, 1'($urandom), 7'($urandom), o);
      if (fw >= TO) begin
         planHalt();
         halted = 1'b1;
         return;
      end
      o.pcWe = 1'b1;
      o.irWe = 1'b1;
      pushCyc(S_FETCH, 1'b1, 1'($urandom), 7'($urandom), o);
      o = '0;
      o.aluSrcB = 2'b11;
      pushCyc(S_DECODE, 1'($urandom), 1'($urandom), opc, o);
      if (!(opc inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR})) begin
         planHalt();
         halted = 1'b1;
         return;
      end
      if (opc == OP_BR) begin
         o = '0;
         o.aluSrcA = 1'b1;
         o.aluOp   = 2'b01;
         o.pcSrc   = 1'b1;
         o.pcWe    = br;
         o.retire  = 1'b1;
         pushCyc(S_BRANCH, 1'($urandom), br, 7'($urandom), o);
         return;
      end
      o = '0;
      o.aluSrcA = 1'b1;
      o.aluSrcB = (opc == OP_R) ? 2'b00 : 2'b10;
      o.aluOp   = (isLoad || isStore) ? 2'b00 : 2'b10;
      pushCyc(S_EXEC, 1'($urandom), 1'($urandom), 7'($urandom), o);
      if (isLoad || isStore) begin
         o = '0;
         o.iord     = 1'b1;
         o.memRead  = isLoad;
         o.memWrite = isStore;
         for (int i = 0; i < ((mw >= TO) ? TO : mw); i++)
            pushCyc(S_MEMACC, 1'b0, 1'($urandom), 7'($urandom), o);
         if (mw >= TO) begin
            planHalt();
            halted = 1'b1;
            return;
         end
         o.retire = isStore;
         pushCyc(S_MEMACC, 1'b1, 1'($urandom), 7'($urandom), o);
         if (isStore) return;
      end
      o = '0;
      o.regWrite = 1'b1;
      o.retire   = 1'b1;
      o.memToReg = isLoad;
      pushCyc(S_WBACK, 1'($urandom), 1'($urandom), 7'($urandom), o);
   endtask

   // Called at a falling edge; replays up to maxCycles planned cycles and ends on a falling edge
   task automatic applyStimulus(input int maxCycles);
      cyc_t c;
      int   n = 0;
      while ((plan.size() > 0) && (n < maxCycles)) begin
         c = plan.pop_front();
         opcode_i    = c.op;
         mem_ready_i = c.rdy;
         brflag_i    = c.br;
         #1;
         checkOutput("state", 32'(state_o), 32'(c.st));
         checkOutput("outputs", 32'(observed()), 32'(c.o));
         @(negedge clk_i);
         cycleNo++;
         n++;
      end
   endtask

   task automatic doReset();
      rst_ni      = 1'b0;
      mem_ready_i = 1'b0;
      #1;
      checkOutput("rst_state", 32'(state_o), 32'(S_FETCH));
      checkOutput("rst_outputs", 32'(observed()), 32'h0);
      mem_ready_i = 1'b1;
      brflag_i    = 1'b1;
      #1;
      checkOutput("rst_outputs_rdy", 32'(observed()), 32'h0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      plan.delete();
   endtask

   function automatic logic [6:0] pickIllegal();
      logic [6:0] op;
      do op = 7'($urandom); while (op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR});
      return op;
   endfunction

   initial begin
      bit         halted;
      logic [6:0] legal[5];
      logic [6:0] opc;
      int         fw, mw;
      legal = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR};

      @(negedge clk_i);
      doReset();

      // Directed: add, lw with two memory waits, beq taken then not taken
      planInstr(OP_R, 0, 0, 1'b0, halted);
      planInstr(OP_LD, 0, 2, 1'b0, halted);
      planInstr(OP_BR, 0, 0, 1'b1, halted);
      planInstr(OP_BR, 0, 0, 1'b0, halted);
      planInstr(OP_ST, 0, 0, 1'b0, halted);
      planInstr(OP_I, 0, 0, 1'b0, halted);
      applyStimulus(1000);

      // Ready on the last allowed wait cycle completes the fetch
      planInstr(OP_R, TO - 1, 0, 1'b0, halted);
      planInstr(OP_ST, 0, TO - 1, 1'b0, halted);
      applyStimulus(1000);

      // Fetch timeout, memory timeout, illegal opcode: each ends in HALT and needs reset
      planInstr(OP_R, TO, 0, 1'b0, halted);
      applyStimulus(1000);
      doReset();
      planInstr(OP_LD, 1, TO, 1'b0, halted);
      applyStimulus(1000);
      doReset();
      planInstr(7'b1111111, 0, 0, 1'b0, halted);
      applyStimulus(1000);
      doReset();

      // Reset in the middle of a store's memory access
      planInstr(OP_ST, 0, 3, 1'b0, halted);
      applyStimulus(3);
      mem_ready_i = 1'b0;
      #1;
      checkOutput("st_memwrite", 32'(memwrite_o), 32'd1);
      #1;
      rst_ni = 1'b0;
      #1;
      checkOutput("st_abort_memwrite", 32'(memwrite_o), 32'd0);
      checkOutput("st_abort_state", 32'(state_o), 32'(S_FETCH));
      checkOutput("st_abort_err", 32'(err_o), 32'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      plan.delete();
      planInstr(OP_R, 0, 0, 1'b0, halted);
      applyStimulus(1000);

      // Randomized instruction stream
      for (int k = 0; k < 60; k++) begin
         opc = ($urandom_range(0, 15) == 0) ? pickIllegal() : legal[$urandom_range(0, 4)];
         fw  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(0, TO + 1);
         mw  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(0, TO + 1);
         planInstr(opc, fw, mw, 1'($urandom), halted);
         applyStimulus(1000);
         if (halted) doReset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL provide parameter TIMEOUT, default 16: maximum number of consecutive wait cycles allowed on a memory handshake.
REQ-002 The block SHALL provide the following ports, one per line.
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- opcode_i  in  7  opcode field of the instruction register (inst[6:0])
- brflag_i  in  1  ALU branch-condition result
- mem_ready_i  in  1  memory handshake complete this cycle
- pc_we_o  out  1  PC register write enable
- ir_we_o  out  1  instruction register write enable
- iord_o  out  1  memory address select: 0 = PC, 1 = ALU result
- memread_o  out  1  memory read request
- memwrite_o  out  1  memory write request
- regwrite_o  out  1  register file write enable
- memtoreg_o  out  1  writeback select: 1 = memory data, 0 = ALU
- alusrca_o  out  1  ALU A select: 0 = PC, 1 = rs1
- alusrcb_o  out  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<1
- aluop_o  out  2  00 = add, 01 = branch compare, 10 = decode from funct fields
- pcsrc_o  out  1  next-PC select: 0 = ALU, 1 = branch target register
- state_o  out  3  current state encoding
- retire_o  out  1  one-cycle pulse per completed instruction
- err_o  out  1  sticky error (timeout or illegal opcode)

Function
REQ-003 The states SHALL be encoded as FETCH=0, DECODE=1, EXEC=2, MEMACC=3, WBACK=4, BRANCH=5, HALT=6.
REQ-004 Outputs SHALL be a function of state, mem_ready_i, brflag_i and the latched opcode; every output not listed for a state SHALL be 0.
REQ-005 In FETCH the block SHALL drive memread_o=1, iord_o=0, alusrca_o=0, alusrcb_o=01 and aluop_o=00.
REQ-006 In FETCH, ir_we_o and pc_we_o SHALL equal mem_ready_i, and the block SHALL go to DECODE on mem_ready_i=1 and otherwise stay in FETCH.
REQ-007 In DECODE the block SHALL latch opcode_i, drive alusrca_o=0 and alusrcb_o=11 (branch target precompute), and last exactly one cycle.
REQ-008 From DECODE the block SHALL go to EXEC for opcodes 0110011, 0010011, 0000011 and 0100011, and to BRANCH for 1100011.
REQ-009 Any other opcode in DECODE SHALL set err_o and send the block to HALT.
REQ-010 In EXEC the block SHALL drive alusrca_o=1.
REQ-011 In EXEC for R-type (0110011) the block SHALL drive alusrcb_o=00 and aluop_o=10, then go to WBACK.
REQ-012 In EXEC for I-ALU (0010011) the block SHALL drive alusrcb_o=10 and aluop_o=10, then go to WBACK.
REQ-013 In EXEC for load and store the block SHALL drive alusrcb_o=10 and aluop_o=00, then go to MEMACC.
REQ-014 In MEMACC the block SHALL drive iord_o=1, with memread_o=1 for a load and memwrite_o=1 for a store.
REQ-015 MEMACC SHALL be held until mem_ready_i=1; a load then goes to WBACK, and a store goes to FETCH with retire_o=1 in that cycle.
REQ-016 In WBACK the block SHALL drive regwrite_o=1 and retire_o=1 for one cycle, with memtoreg_o=1 only for a load, then go to FETCH.
REQ-017 In BRANCH the block SHALL drive alusrca_o=1, alusrcb_o=00, aluop_o=01, pcsrc_o=1, pc_we_o=brflag_i and retire_o=1, then go to FETCH.
REQ-018 A wait counter of width $clog2(TIMEOUT+1) SHALL increment on each cycle in FETCH or MEMACC with mem_ready_i=0, and clear on mem_ready_i=1 or on any state change.
REQ-019 When the wait counter reaches TIMEOUT with mem_ready_i still 0, the block SHALL go to HALT and set err_o=1.
REQ-020 A mem_ready_i arriving in the same cycle the counter reaches TIMEOUT SHALL win: the handshake completes and there is no timeout.
REQ-021 HALT SHALL be terminal until reset, with all enables held at 0 and err_o held at 1.
REQ-022 mem_ready_i outside FETCH and MEMACC SHALL be ignored.
REQ-023 Minimum latency with zero wait states SHALL be: R/I 4 cycles, load 5, store 4, branch 3.

Reset
REQ-024 While rst_ni=0, state SHALL be FETCH, all outputs SHALL be forced to 0 (including memread_o), and the wait counter, latched opcode and err_o SHALL be cleared.
REQ-025 Reset asserted mid-operation (any state, including HALT) SHALL abort immediately, with no write enables pulsed.
REQ-026 The first cycle after reset deassertion SHALL be FETCH with memread_o=1.

Verification
REQ-027 add (opcode 0110011), mem_ready_i=1 -> state_o 0,1,2,4; regwrite_o=1 and retire_o=1 in cycle 4 only.
REQ-028 lw (0000011), mem_ready_i low 2 cycles in MEMACC -> memread_o=1 and iord_o=1 for 3 cycles; then WBACK with memtoreg_o=1 and regwrite_o=1; total 7 cycles.
REQ-029 beq (1100011) with brflag_i=1, then again with brflag_i=0 -> pc_we_o=1 with pcsrc_o=1 in BRANCH; then pc_we_o=0 in BRANCH; 3 cycles each.
REQ-030 TIMEOUT=4, mem_ready_i held 0 in FETCH -> HALT (state_o=6) and err_o=1 after 4 wait cycles; a ready on cycle 4 instead yields DECODE.
REQ-031 opcode 1111111 -> HALT with err_o=1 after DECODE; no regwrite_o or memwrite_o ever asserted.
REQ-032 rst_ni pulsed low during a store's MEMACC -> memwrite_o drops asynchronously; state_o=0 and err_o=0 after release.
